id_ex_register: RTL and testbench
=================================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-002 SHALL have ports hold, flush, id_valid: input 1 each; meaning EX stalled, squash ID/EX, ID holds a real instruction.
REQ-003 SHALL have ports id_pc, id_rs1_data, id_rs2_data, id_imm: input 32 each; ID-stage PC, register-file read data and immediate.
REQ-004 SHALL have ports id_rs1, id_rs2, id_rd: input 5 each; ID source and destination register numbers.
REQ-005 SHALL have ports id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc, id_Branch: input 1 each; ID control bits.
REQ-006 SHALL have port id_ALUOp: input 4; ALU operation.
REQ-007 SHALL have registered outputs id_ex_<field>, one per ID field above, with matching width, plus id_ex_valid output 1.
REQ-008 SHALL have port load_use_stall: output 1, combinational; tells PC and IF/ID to freeze.
REQ-009 SHALL have port bubble_count: output 32; bubble statistic, present only under BUBBLE_CNT_EN.

Function
REQ-010 load_use_stall SHALL = id_ex_valid & id_ex_MemRead & (id_ex_rd!=0) & id_valid & (id_ex_rd==id_rs1 | id_ex_rd==id_rs2).
REQ-011 Each rising clk edge SHALL apply exactly one action, priority order: flush > hold > bubble > load.
REQ-012 Flush SHALL zero every id_ex_* output, id_ex_valid included.
REQ-013 Hold (flush=0) SHALL keep every id_ex_* output unchanged; load_use_stall is ignored while hold=1.
REQ-014 Bubble (flush=0, hold=0, load_use_stall=1 or id_valid=0) SHALL zero every id_ex_* output.
REQ-015 Load (otherwise) SHALL capture all id_* fields into id_ex_* and set id_ex_valid=1.
REQ-016 Latency SHALL be exactly one cycle, ID inputs to id_ex_* outputs.
REQ-017 A zeroed entry SHALL have RegWrite=0, MemWrite=0, rd=0, so the downstream forwarding logic never matches it.
REQ-018 A back-to-back load then dependent use SHALL insert exactly one bubble; the dependent instruction loads on the following edge.
REQ-019 rs1==rs2==id_ex_rd SHALL raise load_use_stall once (single bubble).
REQ-020 A dependent instruction on x0 after a load SHALL NOT stall.

Reset
REQ-021 rst_n=0 SHALL asynchronously zero all id_ex_* outputs, id_ex_valid and bubble_count, regardless of clk.
REQ-022 Reset SHALL dominate flush and hold; the first edge after deassertion follows REQ-011.
REQ-023 Reset asserted mid-hold SHALL discard the held instruction.

Configuration
REQ-024 Macro BUBBLE_CNT_EN defined: bubble_count SHALL increment by 1 on each edge performing flush or bubble, and saturate at 32'hFFFF_FFFF.
REQ-025 Holds and loads SHALL NOT change bubble_count.
REQ-026 Macro BUBBLE_CNT_EN undefined: port bubble_count and the counter SHALL be absent.
REQ-027 All other behaviour SHALL be identical with or without BUBBLE_CNT_EN.

Verification
REQ-028 Reset: rst_n=0 mid-cycle with id_ex_pc=0x40 -> all outputs 0 immediately, before any clk edge.
REQ-029 Load-use: lw x5 (MemRead=1, rd=5) loaded, then ID add rs1=5 -> load_use_stall=1, next edge id_ex_valid=0, following edge add loaded, bubble_count=1.
REQ-030 x0 case: lw rd=0 then ID rs1=0 -> load_use_stall=0, add loads next edge.
REQ-031 Priority: flush=1 and hold=1 with ID pc=0x100 -> outputs zero; hold=1 alone for 3 edges with id_ex_pc=0x80 -> id_ex_pc stays 0x80 and bubble_count unchanged.
REQ-032 Saturation (BUBBLE_CNT_EN): counter forced to 0xFFFF_FFFE, two flush edges -> 0xFFFF_FFFF.
REQ-033 Saturation (BUBBLE_CNT_EN): a further bubble edge -> bubble_count stays 0xFFFF_FFFF.
REQ-034 Build without BUBBLE_CNT_EN -> compiles with port absent; REQ-029 through REQ-031 produce identical id_ex_* traces.

Source files
------------

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with load-use hazard detection.
// Optional saturating bubble counter on port bubble_count, built only when
// the macro BUBBLE_CNT_EN is defined.
module id_ex_register (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_RegWrite,
    input  logic        id_MemRead,
    input  logic        id_MemWrite,
    input  logic        id_MemToReg,
    input  logic        id_ALUSrc,
    input  logic        id_Branch,
    input  logic [3:0]  id_ALUOp,
    output logic [31:0] id_ex_pc,
    output logic [31:0] id_ex_rs1_data,
    output logic [31:0] id_ex_rs2_data,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rs1,
    output logic [4:0]  id_ex_rs2,
    output logic [4:0]  id_ex_rd,
    output logic        id_ex_RegWrite,
    output logic        id_ex_MemRead,
    output logic        id_ex_MemWrite,
    output logic        id_ex_MemToReg,
    output logic        id_ex_ALUSrc,
    output logic        id_ex_Branch,
    output logic [3:0]  id_ex_ALUOp,
    output logic        id_ex_valid,
    output logic        load_use_stall
`ifdef BUBBLE_CNT_EN
    ,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } action_e;

    action_e act;
    logic    ld;
    logic    clr;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rs1_data_q, rs1_data_d;
    logic [31:0] rs2_data_q, rs2_data_d;
    logic [31:0] imm_q, imm_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        alu_src_q, alu_src_d;
    logic        branch_q, branch_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        valid_q, valid_d;

    // A load in EX whose destination is read by the real instruction in ID must wait one cycle; x0 never matches.
    always_comb load_use_stall = valid_q && mem_read_q && (rd_q != 5'd0) && id_valid &&
                                 ((rd_q == id_rs1) || (rd_q == id_rs2));

    // One action per edge, highest priority first; hold masks the hazard so a stalled EX keeps its load.
    always_comb begin
        act = flush ? ACT_FLUSH :
              hold ? ACT_HOLD :
              (load_use_stall || !id_valid) ? ACT_BUBBLE : ACT_LOAD;
        ld  = (act == ACT_LOAD);
        clr = (act == ACT_FLUSH) || (act == ACT_BUBBLE);
    end

    // Next entry: capture ID on load, all-zero on flush/bubble (RegWrite/MemWrite/rd=0 keep forwarding quiet), else keep.
    always_comb begin
        pc_d         = ld ? id_pc       : clr ? 32'd0 : pc_q;
        rs1_data_d   = ld ? id_rs1_data : clr ? 32'd0 : rs1_data_q;
        rs2_data_d   = ld ? id_rs2_data : clr ? 32'd0 : rs2_data_q;
        imm_d        = ld ? id_imm      : clr ? 32'd0 : imm_q;
        rs1_d        = ld ? id_rs1      : clr ? 5'd0  : rs1_q;
        rs2_d        = ld ? id_rs2      : clr ? 5'd0  : rs2_q;
        rd_d         = ld ? id_rd       : clr ? 5'd0  : rd_q;
        reg_write_d  = ld ? id_RegWrite : clr ? 1'b0  : reg_write_q;
        mem_read_d   = ld ? id_MemRead  : clr ? 1'b0  : mem_read_q;
        mem_write_d  = ld ? id_MemWrite : clr ? 1'b0  : mem_write_q;
        mem_to_reg_d = ld ? id_MemToReg : clr ? 1'b0  : mem_to_reg_q;
        alu_src_d    = ld ? id_ALUSrc   : clr ? 1'b0  : alu_src_q;
        branch_d     = ld ? id_Branch   : clr ? 1'b0  : branch_q;
        alu_op_d     = ld ? id_ALUOp    : clr ? 4'd0  : alu_op_q;
        valid_d      = ld ? 1'b1        : clr ? 1'b0  : valid_q;
    end

    // Pipeline register; reset clears it immediately, discarding any held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= 32'd0;
            rs1_data_q   <= 32'd0;
            rs2_data_q   <= 32'd0;
            imm_q        <= 32'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            branch_q     <= 1'b0;
            alu_op_q     <= 4'd0;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src_q    <= alu_src_d;
            branch_q     <= branch_d;
            alu_op_q     <= alu_op_d;
            valid_q      <= valid_d;
        end
    end

    assign id_ex_pc       = pc_q;
    assign id_ex_rs1_data = rs1_data_q;
    assign id_ex_rs2_data = rs2_data_q;
    assign id_ex_imm      = imm_q;
    assign id_ex_rs1      = rs1_q;
    assign id_ex_rs2      = rs2_q;
    assign id_ex_rd       = rd_q;
    assign id_ex_RegWrite = reg_write_q;
    assign id_ex_MemRead  = mem_read_q;
    assign id_ex_MemWrite = mem_write_q;
    assign id_ex_MemToReg = mem_to_reg_q;
    assign id_ex_ALUSrc   = alu_src_q;
    assign id_ex_Branch   = branch_q;
    assign id_ex_ALUOp    = alu_op_q;
    assign id_ex_valid    = valid_q;

`ifdef BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Count every zeroing edge (flush or bubble), sticking at all-ones instead of wrapping.
    always_comb bubble_cnt_d = (clr && (bubble_cnt_q != 32'hFFFF_FFFF)) ? bubble_cnt_q + 32'd1 : bubble_cnt_q;

    // Bubble statistic register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bubble_cnt_q <= 32'd0;
        else        bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: directed bench for id_ex_register with a behavioural entry model and per-cycle compare.
module tb_id_ex_register;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc, id_Branch;
    logic [3:0]  id_ALUOp;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic        id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemToReg, id_ex_ALUSrc, id_ex_Branch;
    logic [3:0]  id_ex_ALUOp;
    logic        id_ex_valid, load_use_stall;
`ifdef BUBBLE_CNT_EN
    logic [31:0] bubble_count;
    logic [31:0] mcnt;
    logic [31:0] saved_cnt;
    logic        cnt_preset = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, m2r, as, br;
        logic [3:0]  op;
        logic        v;
    } ent_t;

    ent_t m, cur, got;
    logic m_stall;

    always #5 clk = ~clk;

    id_ex_register dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_MemToReg(id_MemToReg), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch), .id_ALUOp(id_ALUOp),
        .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
        .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemRead(id_ex_MemRead), .id_ex_MemWrite(id_ex_MemWrite),
        .id_ex_MemToReg(id_ex_MemToReg), .id_ex_ALUSrc(id_ex_ALUSrc), .id_ex_Branch(id_ex_Branch),
        .id_ex_ALUOp(id_ex_ALUOp), .id_ex_valid(id_ex_valid), .load_use_stall(load_use_stall)
`ifdef BUBBLE_CNT_EN
        , .bubble_count(bubble_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ID instruction as the model sees it; a loaded entry is simply this with valid=1.
    always_comb cur = {id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
                       id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc, id_Branch, id_ALUOp, 1'b1};
    always_comb got = {id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd,
                       id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemToReg, id_ex_ALUSrc, id_ex_Branch,
                       id_ex_ALUOp, id_ex_valid};
    always_comb m_stall = m.v && m.mr && (m.rd != 5'd0) && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);

    // Model: the EX entry is empty, kept, or a copy of ID, decided by the priority rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = '0;
`ifdef BUBBLE_CNT_EN
            mcnt = 32'd0;
`endif
        end else begin
`ifdef BUBBLE_CNT_EN
            if (cnt_preset) mcnt = 32'hFFFF_FFFE;
            if ((flush || (!hold && (m_stall || !id_valid))) && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
`endif
            if (flush) m = '0;
            else if (hold) m = m;
            else if (m_stall || !id_valid) m = '0;
            else m = cur;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("pc", got.pc, m.pc);
        chk("rs1_data", got.rs1_data, m.rs1_data);
        chk("rs2_data", got.rs2_data, m.rs2_data);
        chk("imm", got.imm, m.imm);
        chk("regs", {17'd0, got.rs1, got.rs2, got.rd}, {17'd0, m.rs1, m.rs2, m.rd});
        chk("ctrl", {21'd0, got.rw, got.mr, got.mw, got.m2r, got.as, got.br, got.op, got.v},
                    {21'd0, m.rw, m.mr, m.mw, m.m2r, m.as, m.br, m.op, m.v});
        chk("stall", {31'd0, load_use_stall}, {31'd0, m_stall});
`ifdef BUBBLE_CNT_EN
        if (!cnt_preset) chk("bubble_count", bubble_count, mcnt);
`endif
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic mr, input logic v, input logic h, input logic f);
        id_pc = pc; id_rs1_data = pc ^ 32'hA5A5_0000; id_rs2_data = ~pc; id_imm = pc + 32'd4;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_RegWrite = (rd != 5'd0); id_MemRead = mr; id_MemWrite = pc[2]; id_MemToReg = mr;
        id_ALUSrc = pc[3]; id_Branch = pc[4]; id_ALUOp = pc[7:4];
        id_valid = v; hold = h; flush = f;
    endtask

    initial begin
        rst_n = 1'b0;
        id(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("reset_valid", {31'd0, id_ex_valid}, 32'd0);
        rst_n = 1'b1;
        id(32'h40, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick;
        chk("lit_load_pc", id_ex_pc, 32'h40);
        #1 rst_n = 1'b0;
        #1;
        chk("lit_async_rst_pc", id_ex_pc, 32'h0);
        chk("lit_async_rst_valid", {31'd0, id_ex_valid}, 32'd0);
        rst_n = 1'b1;
        id(32'h44, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick;
        id(32'h48, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("lit_lu_stall", {31'd0, load_use_stall}, 32'd1);
        tick;
        chk("lit_lu_bubble_valid", {31'd0, id_ex_valid}, 32'd0);
        chk("lit_lu_bubble_rd", {27'd0, id_ex_rd}, 32'd0);
        tick;
        chk("lit_lu_add_pc", id_ex_pc, 32'h48);
        chk("lit_lu_add_valid", {31'd0, id_ex_valid}, 32'd1);
`ifdef BUBBLE_CNT_EN
        chk("lit_lu_cnt", bubble_count, 32'd1);
`endif
        id(32'h50, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        tick;
        id(32'h54, 5'd9, 5'd9, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("lit_dual_stall", {31'd0, load_use_stall}, 32'd1);
        tick;
        chk("lit_dual_bubble", {31'd0, id_ex_valid}, 32'd0);
        tick;
        chk("lit_dual_pc", id_ex_pc, 32'h54);
        id(32'h60, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick;
        id(32'h64, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("lit_x0_stall", {31'd0, load_use_stall}, 32'd0);
        tick;
        chk("lit_x0_pc", id_ex_pc, 32'h64);
        id(32'h80, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        id(32'h100, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1);
        tick;
        chk("lit_flush_hold_pc", id_ex_pc, 32'h0);
        chk("lit_flush_hold_valid", {31'd0, id_ex_valid}, 32'd0);
        id(32'h80, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
`ifdef BUBBLE_CNT_EN
        saved_cnt = bubble_count;
`endif
        id(32'h84, 5'd1, 5'd2, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("lit_hold_pc", id_ex_pc, 32'h80);
`ifdef BUBBLE_CNT_EN
            chk("lit_hold_cnt", bubble_count, saved_cnt);
`endif
        end
        rst_n = 1'b0;
        #1;
        chk("lit_rst_hold_valid", {31'd0, id_ex_valid}, 32'd0);
        chk("lit_rst_hold_pc", id_ex_pc, 32'h0);
        rst_n = 1'b1;
        id(32'h90, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        chk("lit_invalid_bubble", {31'd0, id_ex_valid}, 32'd0);
        id(32'hA0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick;
        id(32'hA4, 5'd3, 5'd4, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0);
        tick;
        chk("lit_hold_over_lu_pc", id_ex_pc, 32'hA0);
        hold = 1'b0;
        tick;
        chk("lit_release_bubble", {31'd0, id_ex_valid}, 32'd0);
        tick;
        chk("lit_release_pc", id_ex_pc, 32'hA4);
`ifdef BUBBLE_CNT_EN
        cnt_preset = 1'b1;
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.bubble_cnt_q;
        flush = 1'b1;
        tick;
        cnt_preset = 1'b0;
        tick;
        chk("lit_sat_flush", bubble_count, 32'hFFFF_FFFF);
        flush = 1'b0;
        id_valid = 1'b0;
        tick;
        chk("lit_sat_bubble", bubble_count, 32'hFFFF_FFFF);
`endif
        id(32'hB0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        chk("lit_final_pc", id_ex_pc, 32'hB0);
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
